fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Redirect and stall controller for the instruction fetch stage. Sits between the execute stage, decode hazard logic, instruction memory, and an interrupt source, and drives the fetch stage's `stall`, `branch_to_new` and `branch_pc` inputs. It arbitrates redirect sources (taken branch, return-from-interrupt, interrupt vector) and holds a redirect pending while instruction memory is busy. It also sequences pipeline flush, halt and interrupt entry/exit.

## Interface
- `PC_W`, 16: width of all PC values
- `IRQ_VEC`, 16'h0010: interrupt handler entry PC
- `FLUSH_CYC`, 2: cycles `flush` stays high after a redirect; legal range 1-7

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `br_valid`  in  1  execute resolved a taken branch/jump this cycle
- `br_target`  in  PC_W  target PC for `br_valid`
- `reti`  in  1  execute resolved return-from-interrupt this cycle
- `irq_req`  in  1  level-sensitive interrupt request
- `halt_req`  in  1  execute retired a halt instruction (1-cycle pulse)
- `hazard_stall`  in  1  decode load-use stall
- `mem_busy`  in  1  instruction memory cannot accept a new fetch
- `flush_pc`  in  PC_W  PC of the oldest in-flight instruction a flush would squash
- `stall`  out  1  to fetch: hold PC
- `branch_to_new`  out  1  to fetch: load `branch_pc` next edge
- `branch_pc`  out  PC_W  redirect target
- `flush`  out  1  squash decode/execute contents
- `irq_ack`  out  1  1-cycle pulse on interrupt entry
- `epc`  out  PC_W  saved return PC
- `in_handler`  out  1  interrupt handler active
- `halted`  out  1  core halted

## Operation
- FSM states: RUN, FLUSH, HALT.
- Pending redirect register: `pend_v`, `pend_pc`.
- Redirect source priority in RUN, evaluated each cycle:
  - `br_valid` is highest.
  - `reti` is next. When `reti` is taken, the target is `epc` and `in_handler` clears.
  - Interrupt is next, taken when `irq_req & ~in_handler`. On entry: `epc <= flush_pc`, `in_handler` sets, `irq_ack` pulses, and the target is `IRQ_VEC`.
  - `halt_req` is lowest.
- Accepted redirect:
  - `pend_v`/`pend_pc` load the target.
  - `flush` rises the next cycle.
  - The state goes to FLUSH with counter = `FLUSH_CYC`.
- FLUSH state:
  - `br_valid`, `reti` and `halt_req` are ignored, because they come from squashed instructions.
  - `irq_req` is not sampled.
  - Counter decrements each cycle. The state returns to RUN when the counter reaches 0 and `pend_v` = 0.
- Pending issue:
  - When `pend_v & ~mem_busy`, drive `branch_to_new` = 1 and `branch_pc` = `pend_pc` for exactly one cycle, then clear `pend_v`.
  - While `mem_busy` is high, `pend_v` holds and `branch_to_new` = 0.
- `stall` = `hazard_stall | mem_busy | halted | (pend_v & ~branch_to_new)`.
  - `stall` is forced 0 in any cycle where `branch_to_new` = 1.
- HALT state:
  - Entered from RUN on `halt_req` when no higher-priority source is active.
  - `halted` = 1 and `stall` = 1.
  - `irq_req & ~in_handler` wakes the core into interrupt entry, with `epc <= flush_pc`. Otherwise the core exits HALT only via `rst`.
- Reset values: state RUN, `pend_v` 0, `stall` 0, `branch_to_new` 0, `branch_pc` 0, `flush` 0, `irq_ack` 0, `epc` 0, `in_handler` 0, `halted` 0.
- All outputs are registered except `stall`. `stall` is combinational from `hazard_stall`, `mem_busy` and registered state.

## Timing
- `br_valid` sampled at edge N:
  - `branch_to_new`/`flush` high in cycle N+1, when `mem_busy` = 0.
  - Fetch PC equals the target after edge N+2.
- `flush` is high for `FLUSH_CYC` consecutive cycles starting N+1.
- `mem_busy` high for k cycles after acceptance:
  - `branch_to_new` is delayed k cycles.
  - `flush` still starts at N+1; the FLUSH state extends until the issue.
- Simultaneous `br_valid` and `irq_req`: the branch is taken. The interrupt is re-evaluated in the first RUN cycle after FLUSH.
- Simultaneous `reti` and `irq_req`: `reti` is taken. `in_handler` clears, so the interrupt is taken on the first RUN cycle after FLUSH.
- `rst` mid-FLUSH or while `pend_v` = 1: all state returns to reset values at the next edge. The pending redirect is dropped.
- The FLUSH counter is 3 bits and never wraps, because it saturates at 0.

## Test plan
- Branch redirect:
  - Stimulus: after reset, hold `br_valid` = 1 with `br_target` = 16'h0003 for one cycle.
  - Required: `branch_to_new` = 1 and `branch_pc` = 3 for exactly one cycle, next cycle. `flush` = 1 for 2 cycles. `stall` = 0 throughout.
- Busy-held redirect:
  - Stimulus: branch to 16'h0009 with `mem_busy` = 1 for 3 cycles.
  - Required: `stall` = 1 and `branch_to_new` = 0 for 3 cycles. Then a single `branch_to_new` pulse with `branch_pc` = 9.
- Interrupt entry and return:
  - Stimulus: `irq_req` = 1 with `flush_pc` = 16'h0021.
  - Required on entry: `irq_ack` pulse, `branch_pc` = 16'h0010, `epc` = 16'h0021, `in_handler` = 1. A second `irq_req` while `in_handler` = 1 is ignored.
  - Stimulus: `reti`.
  - Required on return: redirect to 16'h0021 and `in_handler` = 0.
- Priority:
  - Stimulus: `br_valid` (target 16'h000C) and `irq_req` in the same cycle.
  - Required: redirect to 12 first, then after 2 flush cycles a redirect to 16'h0010 with `epc` = `flush_pc`.
- Halt/wake:
  - Stimulus: `halt_req` pulse.
  - Required: `halted` = 1 and `stall` = 1 held for 10 cycles.
  - Stimulus: `irq_req`.
  - Required: `halted` = 0 and redirect to 16'h0010.
- Synchronous reset:
  - Stimulus: assert `rst` for one cycle mid-FLUSH while `pend_v` = 1 and `mem_busy` = 1.
  - Required: next cycle all outputs are at reset values and no `branch_to_new` pulse ever issues.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: redirect and stall controller for the instruction fetch stage.
// Arbitrates branch / return-from-interrupt / interrupt redirects, holds a
// redirect pending while instruction memory is busy, and sequences the
// flush, halt and interrupt entry/exit of the pipeline.
//
// Handshake to fetch: branch_to_new is a one-cycle command carrying
// branch_pc; instruction memory signals readiness as ~mem_busy. A redirect is
// issued only on an edge where it is pending (or just accepted) and mem_busy
// is low; otherwise it stays in pend_v/pend_pc and the command is withheld.
module fetch_ctrl #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] IRQ_VEC   = 16'h0010,
    parameter int              FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            reti,
    input  logic            irq_req,
    input  logic            halt_req,
    input  logic            hazard_stall,
    input  logic            mem_busy,
    input  logic [PC_W-1:0] flush_pc,
    output logic            stall,
    output logic            branch_to_new,
    output logic [PC_W-1:0] branch_pc,
    output logic            flush,
    output logic            irq_ack,
    output logic [PC_W-1:0] epc,
    output logic            in_handler,
    output logic            halted,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            pend_v_q, pend_v_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            btn_q, btn_d;
    logic [PC_W-1:0] bpc_q, bpc_d;
    logic            flush_q, flush_d;
    logic            irq_ack_q, irq_ack_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            in_handler_q, in_handler_d;
    logic            halted_q, halted_d;

    logic            take;
    logic [PC_W-1:0] tgt;

    // Next-state: redirect arbitration, pending issue, flush counter and FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        pend_v_d     = pend_v_q;
        pend_pc_d    = pend_pc_q;
        btn_d        = 1'b0;
        bpc_d        = bpc_q;
        irq_ack_d    = 1'b0;
        epc_d        = epc_q;
        in_handler_d = in_handler_q;
        halted_d     = halted_q;
        take         = 1'b0;
        tgt          = pend_pc_q;

        case (state_q)
            ST_RUN: begin
                if (br_valid) begin
                    take = 1'b1;
                    tgt  = br_target;
                end else if (reti) begin
                    take         = 1'b1;
                    tgt          = epc_q;
                    in_handler_d = 1'b0;
                end else if (irq_req && !in_handler_q) begin
                    take         = 1'b1;
                    tgt          = IRQ_VEC;
                    epc_d        = flush_pc;
                    in_handler_d = 1'b1;
                    irq_ack_d    = 1'b1;
                end else if (halt_req) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            ST_HALT: begin
                // Only an interrupt can wake a halted core.
                if (irq_req && !in_handler_q) begin
                    take         = 1'b1;
                    tgt          = IRQ_VEC;
                    epc_d        = flush_pc;
                    in_handler_d = 1'b1;
                    irq_ack_d    = 1'b1;
                    halted_d     = 1'b0;
                end
            end
            default: begin
                // FLUSH: requests come from squashed instructions; ignore them.
            end
        endcase

        if (take) begin
            pend_v_d  = 1'b1;
            pend_pc_d = tgt;
            cnt_d     = FLUSH_INIT;
            state_d   = ST_FLUSH;
        end

        // Issue the pending redirect as soon as memory can accept it; a
        // freshly accepted redirect goes out on the very next cycle.
        if (pend_v_d && !mem_busy) begin
            btn_d    = 1'b1;
            bpc_d    = pend_pc_d;
            pend_v_d = 1'b0;
        end

        flush_d = (cnt_d != 3'd0);

        if (state_d == ST_FLUSH && cnt_d == 3'd0 && !pend_v_d) begin
            state_d = ST_RUN;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= 3'd0;
            pend_v_q     <= 1'b0;
            pend_pc_q    <= '0;
            btn_q        <= 1'b0;
            bpc_q        <= '0;
            flush_q      <= 1'b0;
            irq_ack_q    <= 1'b0;
            epc_q        <= '0;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_v_q     <= pend_v_d;
            pend_pc_q    <= pend_pc_d;
            btn_q        <= btn_d;
            bpc_q        <= bpc_d;
            flush_q      <= flush_d;
            irq_ack_q    <= irq_ack_d;
            epc_q        <= epc_d;
            in_handler_q <= in_handler_d;
            halted_q     <= halted_d;
        end
    end

    // Stall is the only combinational output; never stall while redirecting.
    always_comb begin
        stall = 1'b0;
        if (!btn_q) begin
            stall = hazard_stall | mem_busy | halted_q | pend_v_q;
        end
    end

    assign branch_to_new = btn_q;
    assign branch_pc     = bpc_q;
    assign flush         = flush_q;
    assign irq_ack       = irq_ack_q;
    assign epc           = epc_q;
    assign in_handler    = in_handler_q;
    assign halted        = halted_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: one record per clock cycle
// holding the inputs for that cycle and the outputs expected during it.
module tb_fetch_ctrl;

    localparam int PC_W = 16;

    typedef struct packed {
        logic            rst;
        logic            br_valid;
        logic [PC_W-1:0] br_target;
        logic            reti;
        logic            irq_req;
        logic            halt_req;
        logic            hazard_stall;
        logic            mem_busy;
        logic [PC_W-1:0] flush_pc;
        logic [37:0]     exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            br_valid;
    logic [PC_W-1:0] br_target;
    logic            reti;
    logic            irq_req;
    logic            halt_req;
    logic            hazard_stall;
    logic            mem_busy;
    logic [PC_W-1:0] flush_pc;
    logic            stall;
    logic            branch_to_new;
    logic [PC_W-1:0] branch_pc;
    logic            flush;
    logic            irq_ack;
    logic [PC_W-1:0] epc;
    logic            in_handler;
    logic            halted;
    logic [1:0]      dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t tbl[$];

    fetch_ctrl #(.PC_W(16), .IRQ_VEC(16'h0010), .FLUSH_CYC(2)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_target(br_target),
        .reti(reti), .irq_req(irq_req), .halt_req(halt_req),
        .hazard_stall(hazard_stall), .mem_busy(mem_busy), .flush_pc(flush_pc),
        .stall(stall), .branch_to_new(branch_to_new), .branch_pc(branch_pc),
        .flush(flush), .irq_ack(irq_ack), .epc(epc), .in_handler(in_handler),
        .halted(halted), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Build one cycle record: inputs, then expected
    // {stall, branch_to_new, branch_pc, flush, irq_ack, epc, in_handler, halted}.
    function automatic vec_t mk(
        input logic r, input logic br, input logic [15:0] tg, input logic rt,
        input logic irq, input logic hlt, input logic hz, input logic bsy,
        input logic [15:0] fpc,
        input logic e_stall, input logic e_btn, input logic [15:0] e_bpc,
        input logic e_flush, input logic e_ack, input logic [15:0] e_epc,
        input logic e_inh, input logic e_halted);
        vec_t v;
        v.rst = r; v.br_valid = br; v.br_target = tg; v.reti = rt;
        v.irq_req = irq; v.halt_req = hlt; v.hazard_stall = hz;
        v.mem_busy = bsy; v.flush_pc = fpc;
        v.exp = {e_stall, e_btn, e_bpc, e_flush, e_ack, e_epc, e_inh, e_halted};
        return v;
    endfunction

    // Drive a record on the falling edge, compare just after, away from posedge.
    task automatic run_vec(input vec_t v, input string name);
        logic [37:0] act;
        @(negedge clk);
        rst = v.rst; br_valid = v.br_valid; br_target = v.br_target;
        reti = v.reti; irq_req = v.irq_req; halt_req = v.halt_req;
        hazard_stall = v.hazard_stall; mem_busy = v.mem_busy;
        flush_pc = v.flush_pc;
        #1;
        act = {stall, branch_to_new, branch_pc, flush, irq_ack, epc,
               in_handler, halted};
        n_vec++;
        if (act !== v.exp) begin
            n_fail++;
            $display("FAIL %s: got stall/btn/bpc/flush/ack/epc/inh/halt=%b/%b/%h/%b/%b/%h/%b/%b want %b/%b/%h/%b/%b/%h/%b/%b",
                     name, act[37], act[36], act[35:20], act[19], act[18],
                     act[17:2], act[1], act[0], v.exp[37], v.exp[36],
                     v.exp[35:20], v.exp[19], v.exp[18], v.exp[17:2],
                     v.exp[1], v.exp[0]);
        end
    endtask

    task automatic check_state(input logic [1:0] want, input string name);
        n_vec++;
        if (dbg_state !== want) begin
            n_fail++;
            $display("FAIL %s: dbg_state got %0d want %0d", name, dbg_state, want);
        end
    endtask

    initial begin
        rst = 1'b1; br_valid = 1'b0; br_target = '0; reti = 1'b0;
        irq_req = 1'b0; halt_req = 1'b0; hazard_stall = 1'b0;
        mem_busy = 1'b0; flush_pc = '0;
        repeat (2) @(posedge clk);

        // Reset state and plain branch to 3.
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,0,16'h00,0,0,16'h00,0,0));
        tbl.push_back(mk(0,1,16'h3,0,0,0,0,0,16'h0,   0,0,16'h00,0,0,16'h00,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,1,16'h03,1,0,16'h00,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,0,16'h03,1,0,16'h00,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,1,0,16'h0,   1,0,16'h03,0,0,16'h00,0,0));
        // Branch to 9 with memory busy for the first 3 cycles.
        tbl.push_back(mk(0,1,16'h9,0,0,0,0,1,16'h0,   1,0,16'h03,0,0,16'h00,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,1,16'h0,   1,0,16'h03,1,0,16'h00,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,1,16'h0,   1,0,16'h03,1,0,16'h00,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   1,0,16'h03,0,0,16'h00,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,1,16'h09,0,0,16'h00,0,0));
        // Interrupt entry, second request ignored in handler, then reti.
        tbl.push_back(mk(0,0,16'h0,0,1,0,0,0,16'h21,  0,0,16'h09,0,0,16'h00,0,0));
        tbl.push_back(mk(0,0,16'h0,0,1,0,0,0,16'h21,  0,1,16'h10,1,1,16'h21,1,0));
        tbl.push_back(mk(0,0,16'h0,0,1,0,0,0,16'h21,  0,0,16'h10,1,0,16'h21,1,0));
        tbl.push_back(mk(0,0,16'h0,0,1,0,0,0,16'h33,  0,0,16'h10,0,0,16'h21,1,0));
        tbl.push_back(mk(0,0,16'h0,1,0,0,0,0,16'h0,   0,0,16'h10,0,0,16'h21,1,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,1,16'h21,1,0,16'h21,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,0,16'h21,1,0,16'h21,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,0,16'h21,0,0,16'h21,0,0));
        // Branch and interrupt together: branch first, interrupt after flush.
        tbl.push_back(mk(0,1,16'hC,0,1,0,0,0,16'h55,  0,0,16'h21,0,0,16'h21,0,0));
        tbl.push_back(mk(0,0,16'h0,0,1,0,0,0,16'h55,  0,1,16'h0C,1,0,16'h21,0,0));
        tbl.push_back(mk(0,0,16'h0,0,1,0,0,0,16'h55,  0,0,16'h0C,1,0,16'h21,0,0));
        tbl.push_back(mk(0,0,16'h0,0,1,0,0,0,16'h55,  0,0,16'h0C,0,0,16'h21,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,1,16'h10,1,1,16'h55,1,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,0,16'h10,1,0,16'h55,1,0));
        tbl.push_back(mk(0,0,16'h0,1,0,0,0,0,16'h0,   0,0,16'h10,0,0,16'h55,1,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,1,16'h55,1,0,16'h55,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,0,16'h55,1,0,16'h55,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,0,16'h0,   0,0,16'h55,0,0,16'h55,0,0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

        // Halt: held for 10 cycles, a branch during halt is ignored.
        run_vec(mk(0,0,16'h0,0,0,1,0,0,16'h0, 0,0,16'h55,0,0,16'h55,0,0), "halt_req");
        for (int i = 0; i < 10; i++) begin
            run_vec(mk(0, (i == 3), 16'h77, 0,0,0,0,0,16'h0,
                       1,0,16'h55,0,0,16'h55,0,1), $sformatf("halt_hold%0d", i));
            if (i == 5) check_state(2'd2, "halt_state");
        end
        // Wake by interrupt.
        run_vec(mk(0,0,16'h0,0,1,0,0,0,16'h40, 1,0,16'h55,0,0,16'h55,0,1), "wake_req");
        run_vec(mk(0,0,16'h0,0,0,0,0,0,16'h0,  0,1,16'h10,1,1,16'h40,1,0), "wake_redir");
        run_vec(mk(0,0,16'h0,0,0,0,0,0,16'h0,  0,0,16'h10,1,0,16'h40,1,0), "wake_flush");

        // Reset mid-flush with a redirect pending behind a busy memory.
        run_vec(mk(0,1,16'h5A,0,0,0,0,1,16'h0, 1,0,16'h10,0,0,16'h40,1,0), "rst_br");
        run_vec(mk(0,0,16'h0,0,0,0,0,1,16'h0,  1,0,16'h10,1,0,16'h40,1,0), "rst_pend");
        run_vec(mk(1,0,16'h0,0,0,0,0,1,16'h0,  1,0,16'h10,1,0,16'h40,1,0), "rst_assert");
        for (int i = 0; i < 6; i++) begin
            run_vec(mk(0,0,16'h0,0,0,0,0,0,16'h0, 0,0,16'h00,0,0,16'h00,0,0),
                    $sformatf("rst_after%0d", i));
            if (i == 0) check_state(2'd0, "rst_state");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
